// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: fetch/decode/execute/memory/write-back
// sequencer driving datapath strobes and selects from a 4-bit state register.
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-low reset
//   instr_op_i   - opcode field of the instruction register
//   zero_i       - ALU zero flag (branch resolution)
//   mem_ready_i  - memory access completes this cycle
//   pc_write_o   - load PC
//   ir_write_o   - load instruction register
//   mem_read_o   - memory read strobe
//   mem_write_o  - memory write strobe
//   reg_write_o  - register file write enable
//   reg_dst_o    - write-back address select (1 = rd)
//   mem_to_reg_o - write-back data select (1 = memory)
//   alu_src_a_o  - ALU A select (0 = PC, 1 = rs)
//   alu_src_b_o  - ALU B select (rt / 4 / imm / imm<<2)
//   alu_op_o     - ALU op class (add / sub / funct / slt)
//   illegal_o    - one-cycle pulse on unsupported opcode
//   state_o      - current state code (debug)
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] instr_op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IF       = 4'd0,
        S_ID       = 4'd1,
        S_EX_R     = 4'd2,
        S_EX_I     = 4'd3,
        S_EX_BR    = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_R     = 4'd8,
        S_WB_I     = 4'd9,
        S_WB_MEM   = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_SLTI = 6'd10;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_SLT   = 2'b11;

    state_t     r_state;
    logic [5:0] r_op;
    logic       w_legal;

    always_comb begin
        w_legal = (instr_op_i == OP_R)    ||
                  (instr_op_i == OP_ADDI) ||
                  (instr_op_i == OP_SLTI) ||
                  (instr_op_i == OP_BEQ)  ||
                  (instr_op_i == OP_BNE)  ||
                  (instr_op_i == OP_LW)   ||
                  (instr_op_i == OP_SW);
    end

    // State register and opcode latch. The opcode is captured in ID so later
    // changes on instr_op_i cannot redirect an instruction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IF;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_IF: begin
                    if (mem_ready_i)
                        r_state <= S_ID;
                end
                S_ID: begin
                    r_op <= instr_op_i;
                    if (instr_op_i == OP_R)
                        r_state <= S_EX_R;
                    else if (instr_op_i == OP_ADDI ||
                             instr_op_i == OP_SLTI)
                        r_state <= S_EX_I;
                    else if (instr_op_i == OP_BEQ ||
                             instr_op_i == OP_BNE)
                        r_state <= S_EX_BR;
                    else if (instr_op_i == OP_LW ||
                             instr_op_i == OP_SW)
                        r_state <= S_MEM_ADDR;
                    else
                        r_state <= S_IF;
                end
                S_EX_R:  r_state <= S_WB_R;
                S_EX_I:  r_state <= S_WB_I;
                S_EX_BR: r_state <= S_IF;
                S_MEM_ADDR: begin
                    if (r_op == OP_SW)
                        r_state <= S_MEM_WR;
                    else
                        r_state <= S_MEM_RD;
                end
                S_MEM_RD: begin
                    if (mem_ready_i)
                        r_state <= S_WB_MEM;
                end
                S_MEM_WR: begin
                    if (mem_ready_i)
                        r_state <= S_IF;
                end
                S_WB_R:   r_state <= S_IF;
                S_WB_I:   r_state <= S_IF;
                S_WB_MEM: r_state <= S_IF;
                default:  r_state <= S_IF;
            endcase
        end
    end

    // Outputs decode the state directly. The few same-cycle dependencies
    // (fetch completion, branch resolution, illegal opcode) are gated so that
    // an asserted reset never lets a write strobe through.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RT;
        alu_op_o     = ALU_ADD;
        illegal_o    = 1'b0;
        case (r_state)
            S_IF: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i & rst_i;
                pc_write_o  = mem_ready_i & rst_i;
            end
            S_ID: begin
                alu_src_b_o = SRCB_BOFF;
                illegal_o   = ~w_legal;
            end
            S_EX_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_FUNCT;
            end
            S_EX_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = (r_op == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_EX_BR: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALU_SUB;
                pc_write_o  = (r_op == OP_BNE) ? ~zero_i : zero_i;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
            end
            S_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_WB_I: begin
                reg_write_o = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic       ir_write_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [1:0] alu_op_o;
    logic       illegal_o;
    logic [3:0] state_o;

    multicycle_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_op_i   (instr_op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .ir_write_o   (ir_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Vector: {state[3:0], pc_w, ir_w, mrd, mwr, rw, rdst, m2r,
    //          src_a, src_b[1:0], alu_op[1:0], illegal}
    localparam logic [16:0] E_IF_W   = {4'd0,  7'b0010000, 1'b0, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] E_IF_G   = {4'd0,  7'b1110000, 1'b0, 2'b01, 2'b00, 1'b0};
    localparam logic [16:0] E_ID     = {4'd1,  7'b0000000, 1'b0, 2'b11, 2'b00, 1'b0};
    localparam logic [16:0] E_ID_ILL = {4'd1,  7'b0000000, 1'b0, 2'b11, 2'b00, 1'b1};
    localparam logic [16:0] E_EXR    = {4'd2,  7'b0000000, 1'b1, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] E_EXI_A  = {4'd3,  7'b0000000, 1'b1, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] E_EXI_S  = {4'd3,  7'b0000000, 1'b1, 2'b10, 2'b11, 1'b0};
    localparam logic [16:0] E_BR_T   = {4'd4,  7'b1000000, 1'b1, 2'b00, 2'b01, 1'b0};
    localparam logic [16:0] E_BR_N   = {4'd4,  7'b0000000, 1'b1, 2'b00, 2'b01, 1'b0};
    localparam logic [16:0] E_MA     = {4'd5,  7'b0000000, 1'b1, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] E_MRD    = {4'd6,  7'b0010000, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MWR    = {4'd7,  7'b0001000, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_WBR    = {4'd8,  7'b0000110, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_WBI    = {4'd9,  7'b0000100, 1'b0, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_WBM    = {4'd10, 7'b0000101, 1'b0, 2'b00, 2'b00, 1'b0};

    typedef struct {
        string       name;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    logic [16:0] w_got;
    assign w_got = {state_o, pc_write_o, ir_write_o, mem_read_o, mem_write_o,
                    reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o,
                    alu_src_b_o, alu_op_o, illegal_o};

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (w_got !== e.v) begin
                bad++;
                $display("FAIL %s: got=%05h want=%05h (state got=%0d want=%0d)",
                         e.name, w_got, e.v, w_got[16:13], e.v[16:13]);
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic step(input logic rst, input logic rdy, input logic z,
                        input logic [5:0] op, input logic [16:0] v,
                        input string name);
        exp_t e;
        rst_i       = rst;
        mem_ready_i = rdy;
        zero_i      = z;
        instr_op_i  = op;
        e.name = name;
        e.v    = v;
        q.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b0;
        mem_ready_i = 1'b1;
        zero_i      = 1'b0;
        instr_op_i  = 6'd0;
        @(posedge clk_i);
        #1;
        step(0, 1, 0, 6'd0,  E_IF_W,   "reset_if");
        step(1, 0, 0, 6'd0,  E_IF_W,   "if_wait");
        // add
        step(1, 1, 0, 6'd0,  E_IF_G,   "add_if");
        step(1, 1, 0, 6'd0,  E_ID,     "add_id");
        step(1, 1, 0, 6'd0,  E_EXR,    "add_exr");
        step(1, 1, 0, 6'd0,  E_WBR,    "add_wbr");
        // lw with 3 wait cycles
        step(1, 1, 0, 6'd0,  E_IF_G,   "lw_if");
        step(1, 1, 0, 6'd35, E_ID,     "lw_id");
        step(1, 1, 0, 6'd35, E_MA,     "lw_ma");
        step(1, 0, 0, 6'd35, E_MRD,    "lw_rd_w1");
        step(1, 0, 0, 6'd35, E_MRD,    "lw_rd_w2");
        step(1, 0, 0, 6'd35, E_MRD,    "lw_rd_w3");
        step(1, 1, 0, 6'd35, E_MRD,    "lw_rd_go");
        step(1, 1, 0, 6'd35, E_WBM,    "lw_wbm");
        // lw with opcode changed after ID
        step(1, 1, 0, 6'd0,  E_IF_G,   "lw2_if");
        step(1, 1, 0, 6'd35, E_ID,     "lw2_id");
        step(1, 1, 0, 6'd43, E_MA,     "lw2_ma");
        step(1, 1, 0, 6'd43, E_MRD,    "lw2_rd");
        step(1, 1, 0, 6'd43, E_WBM,    "lw2_wbm");
        // sw
        step(1, 1, 0, 6'd0,  E_IF_G,   "sw_if");
        step(1, 1, 0, 6'd43, E_ID,     "sw_id");
        step(1, 1, 0, 6'd43, E_MA,     "sw_ma");
        step(1, 1, 0, 6'd43, E_MWR,    "sw_wr");
        // branches
        step(1, 1, 0, 6'd0,  E_IF_G,   "beq1_if");
        step(1, 1, 0, 6'd4,  E_ID,     "beq1_id");
        step(1, 1, 1, 6'd4,  E_BR_T,   "beq_z1");
        step(1, 1, 0, 6'd0,  E_IF_G,   "bne1_if");
        step(1, 1, 0, 6'd5,  E_ID,     "bne1_id");
        step(1, 1, 1, 6'd5,  E_BR_N,   "bne_z1");
        step(1, 1, 0, 6'd0,  E_IF_G,   "beq0_if");
        step(1, 1, 0, 6'd4,  E_ID,     "beq0_id");
        step(1, 1, 0, 6'd5,  E_BR_N,   "beq_z0");
        step(1, 1, 0, 6'd0,  E_IF_G,   "bne0_if");
        step(1, 1, 0, 6'd5,  E_ID,     "bne0_id");
        step(1, 1, 0, 6'd4,  E_BR_T,   "bne_z0");
        // illegal opcode
        step(1, 1, 0, 6'd0,  E_IF_G,   "ill_if");
        step(1, 1, 0, 6'd63, E_ID_ILL, "ill_id");
        step(1, 0, 0, 6'd63, E_IF_W,   "ill_next");
        // addi, opcode flipped to slti during EX_I
        step(1, 1, 0, 6'd0,  E_IF_G,   "addi_if");
        step(1, 1, 0, 6'd8,  E_ID,     "addi_id");
        step(1, 1, 0, 6'd10, E_EXI_A,  "addi_ex");
        step(1, 1, 0, 6'd10, E_WBI,    "addi_wb");
        // slti
        step(1, 1, 0, 6'd0,  E_IF_G,   "slti_if");
        step(1, 1, 0, 6'd10, E_ID,     "slti_id");
        step(1, 1, 0, 6'd8,  E_EXI_S,  "slti_ex");
        step(1, 1, 0, 6'd8,  E_WBI,    "slti_wb");
        // reset during a memory write wait
        step(1, 1, 0, 6'd0,  E_IF_G,   "swr_if");
        step(1, 1, 0, 6'd43, E_ID,     "swr_id");
        step(1, 1, 0, 6'd43, E_MA,     "swr_ma");
        step(1, 0, 0, 6'd43, E_MWR,    "swr_wait");
        step(0, 1, 0, 6'd43, E_IF_W,   "swr_rst");
        step(1, 0, 0, 6'd43, E_IF_W,   "post_rst_if");
        // recovery: add after reset
        step(1, 1, 0, 6'd0,  E_IF_G,   "rec_if");
        step(1, 1, 0, 6'd0,  E_ID,     "rec_id");
        step(1, 1, 0, 6'd0,  E_EXR,    "rec_exr");
        step(1, 1, 0, 6'd0,  E_WBR,    "rec_wbr");
        step(1, 0, 0, 6'd0,  E_IF_W,   "rec_if2");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_i);
        #1;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
